// File: rtl/adrv9001_tdd_seq.sv
// adrv9001_tdd_seq: per-channel TDD sequencer that times the channel enable pin and SSI datapath enable from a level request.
module adrv9001_tdd_seq #(
  parameter int CNT_W = 32
) (
  input  logic             s_axi_aclk,
  input  logic             s_axi_aresetn,
  input  logic             tdd_en,
  input  logic [CNT_W-1:0] ssi_enable_cnt,
  input  logic [CNT_W-1:0] disable_cnt,
  input  logic [CNT_W-1:0] ssi_disable_cnt,
  output logic             enable,
  output logic             ssi_enable,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {IDLE, SSI_WAIT, ACTIVE, DIS_WAIT} state_t;
  localparam logic [CNT_W-1:0] ONE = 1;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, on_q, on_d, dis_q, dis_d, sdis_q, sdis_d;
  logic             en_q, en_d, ssi_q, ssi_d, busy_q, busy_d, done_q, done_d;
  // A count N fires on the edge where the counter holds N-1, so 2^CNT_W-1 never wraps.
  always_comb begin
    state_d = state_q;
    on_d    = on_q;
    dis_d   = dis_q;
    sdis_d  = sdis_q;
    en_d    = en_q;
    ssi_d   = ssi_q;
    case (state_q)
      IDLE: if (tdd_en) begin
        on_d    = ssi_enable_cnt;
        en_d    = 1'b1;
        ssi_d   = ssi_enable_cnt == '0;
        state_d = ssi_d ? ACTIVE : SSI_WAIT;
      end
      SSI_WAIT: if (!tdd_en) begin
        dis_d   = disable_cnt;
        sdis_d  = '0;
        en_d    = disable_cnt != '0;
        state_d = DIS_WAIT;
      end else if (cnt_q == on_q - ONE) begin
        ssi_d   = 1'b1;
        state_d = ACTIVE;
      end
      ACTIVE: if (!tdd_en) begin
        dis_d   = disable_cnt;
        sdis_d  = ssi_disable_cnt;
        en_d    = disable_cnt != '0;
        ssi_d   = ssi_disable_cnt != '0;
        state_d = DIS_WAIT;
      end
      DIS_WAIT: begin
        en_d  = en_q && cnt_q != dis_q - ONE;
        ssi_d = ssi_q && cnt_q != sdis_q - ONE;
      end
    endcase
    if (state_d == DIS_WAIT && !en_d && !ssi_d) state_d = IDLE;
    done_d = state_q != IDLE && state_d == IDLE;
    busy_d = state_d != IDLE;
    cnt_d  = (state_d == state_q && (state_q == SSI_WAIT || state_q == DIS_WAIT)) ? cnt_q + ONE : '0;
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      on_q    <= '0;
      dis_q   <= '0;
      sdis_q  <= '0;
      en_q    <= 1'b0;
      ssi_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      on_q    <= on_d;
      dis_q   <= dis_d;
      sdis_q  <= sdis_d;
      en_q    <= en_d;
      ssi_q   <= ssi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign enable     = en_q;
  assign ssi_enable = ssi_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign state      = state_q;
endmodule

// File: tb/tb_adrv9001_tdd_seq.sv
// tb_adrv9001_tdd_seq: directed bench; inputs change on negedges, outputs are checked on negedges.
`timescale 1ns/1ps
module tb_adrv9001_tdd_seq;
  logic        clk, rst_n, tdd_en, enable, ssi_enable, busy, done;
  logic [31:0] on_cnt, dis_cnt, sdis_cnt;
  logic [1:0]  state;
  int          pass_n, total_n;
  adrv9001_tdd_seq #(.CNT_W(32)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .tdd_en(tdd_en),
    .ssi_enable_cnt(on_cnt), .disable_cnt(dis_cnt), .ssi_disable_cnt(sdis_cnt),
    .enable(enable), .ssi_enable(ssi_enable), .busy(busy), .done(done), .state(state)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic outs(input string tag, input logic en, input logic ssi, input logic [1:0] st, input logic bz, input logic dn);
    chk({tag, ".enable"}, 32'(enable), 32'(en));
    chk({tag, ".ssi_enable"}, 32'(ssi_enable), 32'(ssi));
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
    chk({tag, ".done"}, 32'(done), 32'(dn));
  endtask
  initial begin
    pass_n = 0; total_n = 0;
    rst_n = 1'b1; tdd_en = 1'b0; on_cnt = 0; dis_cnt = 0; sdis_cnt = 0;
    #2 rst_n = 1'b0;
    step(2);
    outs("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(1);
    // start with ssi_enable_cnt=20, input changed to 3 mid-wait
    on_cnt = 20; tdd_en = 1'b1;
    step(1);  outs("start_t1", 1, 0, 1, 1, 0);
    step(4);  on_cnt = 3;
    step(15); outs("start_t20", 1, 0, 1, 1, 0);
    step(1);  outs("start_t21", 1, 1, 2, 1, 0);
    // stop with disable 100 / ssi_disable 130, re-request during the wait
    dis_cnt = 100; sdis_cnt = 130; tdd_en = 1'b0;
    step(1);  outs("stop_t1", 1, 1, 3, 1, 0);
    step(99); outs("stop_t100", 1, 1, 3, 1, 0);
    step(1);  outs("stop_t101", 0, 1, 3, 1, 0);
    step(19); tdd_en = 1'b1;
    step(10); outs("stop_t130", 0, 1, 3, 1, 0);
    step(1);  outs("stop_t131", 0, 0, 0, 0, 1);
    step(1);  outs("restart_t1", 1, 0, 1, 1, 0);
    step(3);  outs("restart_t4", 1, 1, 2, 1, 0);
    // TX profile
    dis_cnt = 100; sdis_cnt = 0; tdd_en = 1'b0;
    step(1);  outs("tx_t1", 1, 0, 3, 1, 0);
    step(99); outs("tx_t100", 1, 0, 3, 1, 0);
    step(1);  outs("tx_t101", 0, 0, 0, 0, 1);
    // abort during SSI_WAIT
    on_cnt = 50; dis_cnt = 5; sdis_cnt = 77; tdd_en = 1'b1;
    step(1);  outs("abort_t1", 1, 0, 1, 1, 0);
    step(9);  outs("abort_t10", 1, 0, 1, 1, 0);
    tdd_en = 1'b0;
    step(1);  outs("abort_t11", 1, 0, 3, 1, 0);
    step(4);  outs("abort_t15", 1, 0, 3, 1, 0);
    step(1);  outs("abort_t16", 0, 0, 0, 0, 1);
    step(1);  outs("abort_t17", 0, 0, 0, 0, 0);
    // all counts zero
    on_cnt = 0; dis_cnt = 0; sdis_cnt = 0; tdd_en = 1'b1;
    step(1);  outs("zero_on", 1, 1, 2, 1, 0);
    step(2);  outs("zero_hold", 1, 1, 2, 1, 0);
    tdd_en = 1'b0;
    step(1);  outs("zero_off", 0, 0, 0, 0, 1);
    step(1);  outs("zero_idle", 0, 0, 0, 0, 0);
    // asynchronous reset while ACTIVE
    tdd_en = 1'b1;
    step(2);  outs("areset_pre", 1, 1, 2, 1, 0);
    #2 rst_n = 1'b0;
    #1 outs("areset", 0, 0, 0, 0, 0);
    step(1);
    rst_n = 1'b1; tdd_en = 1'b0;
    step(2);  outs("areset_post", 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/adrv9001_tdd_seq.md
Name: adrv9001_tdd_seq

Overview:
- Per-channel TDD enable sequencer for one ADRV9001 TX or RX channel.
- Turns a level request from the register block (txN_tdd_en / rxN_tdd_en) into timed control of two signals: the device channel enable pin, and the SSI datapath enable.
- Delays come from the register block's disable / ssi_enable / ssi_disable counts.
- Instantiated four times (TX1, TX2, RX1, RX2). TX instances tie ssi_disable_cnt to 0.

Parameters:
- CNT_W, 32, width of the count inputs and of the internal cycle counter.

Ports:
- s_axi_aclk  in  1  sequencer clock. The only clock.
- s_axi_aresetn  in  1  asynchronous active-low reset.
- tdd_en  in  1  level request: 1 = channel on, 0 = channel off.
- ssi_enable_cnt  in  CNT_W  cycles from enable rising to ssi_enable rising.
- disable_cnt  in  CNT_W  cycles from request drop to enable falling.
- ssi_disable_cnt  in  CNT_W  cycles from request drop to ssi_enable falling.
- enable  out  1  device channel enable pin (TX_EN / RX_EN).
- ssi_enable  out  1  SSI datapath enable.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when the sequence returns to IDLE.
- state  out  2  current state: 0 IDLE, 1 SSI_WAIT, 2 ACTIVE, 3 DISABLE_WAIT.

Behaviour:
- Reset (asynchronous): enable=0, ssi_enable=0, busy=0, done=0, state=IDLE, counter=0, latched counts=0. Reset mid-sequence drops both enables at once, with no disable timing.
- All outputs are registered. Cycle t is the first rising edge at which a new tdd_en level is sampled.
- Counts are latched into internal registers on the start transition and on the stop transition. Changes to the count inputs at any other time have no effect on the sequence in progress.

IDLE:
- tdd_en=0: stay.
- tdd_en=1: latch ssi_enable_cnt. enable=1 at t+1.
  - ssi_enable_cnt=0: ssi_enable=1 at t+1; go to ACTIVE.
  - otherwise: go to SSI_WAIT.

SSI_WAIT:
- ssi_enable rises at t+1+ssi_enable_cnt; go to ACTIVE.
- If tdd_en is sampled 0 before that: abort to DISABLE_WAIT. ssi_enable never rises. The stop edge becomes the new t.

ACTIVE:
- Hold enable=1, ssi_enable=1 while tdd_en=1.
- tdd_en sampled 0 at t: latch disable_cnt and ssi_disable_cnt; go to DISABLE_WAIT.

DISABLE_WAIT:
- enable falls at t+1+disable_cnt.
- ssi_enable falls at t+1+ssi_disable_cnt. A count of 0 means it falls at t+1.
- When both outputs are low, go to IDLE at t+1+max(disable_cnt, ssi_disable_cnt). done pulses that same cycle.
- tdd_en re-asserted here is ignored until IDLE. IDLE then starts a new sequence on the next edge if tdd_en is still 1. Minimum off-to-on gap is one IDLE cycle.
- If both counts are 0: both outputs fall at t+1 and the state returns to IDLE at t+1.

Counter:
- Unsigned CNT_W bits, cleared on each transition. A maximum count of 2^CNT_W-1 must not wrap before it matches.
- tdd_en is assumed already synchronous to s_axi_aclk. The register block drives it in this domain.

Test Plan:
- Reset then tdd_en=1 at t with ssi_enable_cnt=20 -> enable=1 at t+1; ssi_enable=1 at t+21; state sequence 0→1→2.
- From ACTIVE with disable_cnt=100, ssi_disable_cnt=130, tdd_en=0 at t -> enable=0 at t+101; ssi_enable=0 at t+131; done pulses at t+131 for exactly one cycle; busy=0 from t+131.
- TX profile: ssi_disable_cnt=0, disable_cnt=100, tdd_en drop at t -> ssi_enable=0 at t+1; enable=0 at t+101.
- Abort: ssi_enable_cnt=50, tdd_en pulse high for 10 cycles, disable_cnt=5 -> ssi_enable stays 0 throughout; enable high t+1..t+10, low at t+16 (drop sampled at t+10); then IDLE.
- Count change mid-sequence: in SSI_WAIT with ssi_enable_cnt=20, change the input to 3 at t+5 -> ssi_enable still rises at t+21. Re-assert tdd_en during DISABLE_WAIT -> new start only after done.
- Zero counts and async reset: all counts 0 -> enable and ssi_enable rise together at t+1 and fall together at t'+1. Assert s_axi_aresetn=0 in ACTIVE -> both outputs 0 immediately, without waiting for a clock edge; state=0.
